// File: rtl/popcount_pkg.sv
// Shared constants and width helpers for the pipelined population counter.
// Optional Conway-rule evaluation is enabled with POPCOUNT_LIFE_RULE_EN.
package popcount_pkg;

  localparam int unsigned LIFE_BIRTH   = 3;
  localparam int unsigned LIFE_SURVIVE = 2;

  function automatic int unsigned pc_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  // Bit offset of tree level k inside the flattened level bus.
  // Level j holds (n >> j) sums of (j + 1) bits each.
  function automatic int unsigned lvl_base(input int unsigned n, input int unsigned k);
    int unsigned acc;
    acc = 0;
    for (int unsigned j = 0; j < k; j++) begin
      acc += (n >> j) * (j + 1);
    end
    return acc;
  endfunction

endpackage

// File: rtl/adder_n.sv
// Generic WIDTH-bit ripple adder with carry in/out, shared across datapaths.
module adder_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/popcount_stage.sv
// One registered adder-tree level: PAIRS adders of IN_W bits, holds while !adv.
// The center sideband register exists only with POPCOUNT_LIFE_RULE_EN.
module popcount_stage
  import popcount_pkg::*;
#(
  parameter int PAIRS = 1,
  parameter int IN_W  = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        adv_i,
  input  logic                        valid_i,
  input  logic [2*PAIRS*IN_W-1:0]     sums_i,
`ifdef POPCOUNT_LIFE_RULE_EN
  input  logic                        center_i,
  output logic                        center_o,
`endif
  output logic                        valid_o,
  output logic [PAIRS*(IN_W+1)-1:0]   sums_o
);

  localparam int OW = IN_W + 1;

  logic [PAIRS*OW-1:0] sums_d;
  logic [PAIRS*OW-1:0] sums_q;
  logic                valid_q;
`ifdef POPCOUNT_LIFE_RULE_EN
  logic                center_q;
`endif

  for (genvar p = 0; p < PAIRS; p++) begin : g_pair
    logic [IN_W-1:0] sum;
    logic            carry;

    adder_n #(.WIDTH(IN_W)) u_add (
      .a_i   (sums_i[(2*p)*IN_W +: IN_W]),
      .b_i   (sums_i[(2*p+1)*IN_W +: IN_W]),
      .cin_i (1'b0),
      .sum_o (sum),
      .cout_o(carry)
    );

    assign sums_d[p*OW +: OW] = {carry, sum};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      sums_q   <= '0;
`ifdef POPCOUNT_LIFE_RULE_EN
      center_q <= 1'b0;
`endif
    end else if (adv_i) begin
      valid_q  <= valid_i;
      sums_q   <= sums_d;
`ifdef POPCOUNT_LIFE_RULE_EN
      center_q <= center_i;
`endif
    end
  end

  assign valid_o  = valid_q;
  assign sums_o   = sums_q;
`ifdef POPCOUNT_LIFE_RULE_EN
  assign center_o = center_q;
`endif

endmodule

// File: rtl/popcount_pipe.sv
// Pipelined N-bit population counter, one adder-tree level per stage, valid/ready.
// Define POPCOUNT_LIFE_RULE_EN to produce the Conway next-state on next_alive.
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int N = 8,
  parameter int W = pc_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] items,
  input  logic         center,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] count,
  output logic         next_alive
);

  localparam int S        = $clog2(N);
  localparam int TOT      = int'(lvl_base(N, S + 1));
  localparam int LAST_OFF = int'(lvl_base(N, S));

  logic           adv;
  // All tree levels packed back to back; level 0 is the raw input vector.
  logic [TOT-1:0] lvl;
  logic [S:0]     vld;
`ifdef POPCOUNT_LIFE_RULE_EN
  logic [S:0]     ctr;
  assign ctr[0] = center;
`endif

  assign lvl[N-1:0] = items;
  assign vld[0]     = in_valid;

  for (genvar k = 1; k <= S; k++) begin : g_stage
    localparam int PAIRS    = N >> k;
    localparam int IN_BASE  = int'(lvl_base(N, k - 1));
    localparam int OUT_BASE = int'(lvl_base(N, k));

    popcount_stage #(
      .PAIRS(PAIRS),
      .IN_W (k)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (rst),
      .adv_i   (adv),
      .valid_i (vld[k-1]),
      .sums_i  (lvl[IN_BASE +: 2*PAIRS*k]),
`ifdef POPCOUNT_LIFE_RULE_EN
      .center_i(ctr[k-1]),
      .center_o(ctr[k]),
`endif
      .valid_o (vld[k]),
      .sums_o  (lvl[OUT_BASE +: PAIRS*(k+1)])
    );
  end

  assign out_valid = vld[S];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign count     = lvl[LAST_OFF +: W];

`ifdef POPCOUNT_LIFE_RULE_EN
  // Decoded purely from stage-S registers, so it is stable with count under backpressure.
  assign next_alive = (count == W'(LIFE_BIRTH)) || (ctr[S] && (count == W'(LIFE_SURVIVE)));
`else
  logic unused_center;
  assign unused_center = center;
  assign next_alive    = 1'b0;
`endif

endmodule
